// File: rtl/lut_result_pack_pkg.sv
// Shared lane geometry, lane decode and fill-FSM state type for the PIM LUT
// lookup and result-pack paths.
package lut_result_pack_pkg;

  localparam int NUM_LANE   = 16;
  localparam int LANE_W     = 16;
  localparam int ROW_W      = NUM_LANE * LANE_W;
  localparam int LANE_IDX_W = $clog2(NUM_LANE);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } fill_state_e;

  function automatic logic [NUM_LANE-1:0] lane_onehot(input logic [LANE_IDX_W-1:0] idx);
    logic [NUM_LANE-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/lut_row_slot.sv
// Single-entry valid/ready output register holding one packed row and its lane mask.
// Handshake: a row transfers on any cycle where o_valid & i_ready; data/mask hold while o_valid & !i_ready.
module lut_row_slot
  import lut_result_pack_pkg::*;
(
  input  logic                clk,
  input  logic                rst_x,
  input  logic                i_load,
  input  logic [ROW_W-1:0]    i_data,
  input  logic [NUM_LANE-1:0] i_mask,
  input  logic                i_ready,
  output logic                o_valid,
  output logic [ROW_W-1:0]    o_data,
  output logic [NUM_LANE-1:0] o_mask,
  output logic                o_free
);

  logic                r_valid;
  logic [ROW_W-1:0]    r_data;
  logic [NUM_LANE-1:0] r_mask;

  // Free now, or emptying at this edge, so a new row may be loaded in the same cycle.
  assign o_free  = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_mask  = r_mask;

  always_ff @(posedge clk) begin
    if (rst_x) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_mask  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_mask  <= i_mask;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/lut_result_pack.sv
// Gathers per-lane LUT results into a packed row plus lane mask and hands completed
// or flushed rows to the bank write port. Lane geometry comes from lut_result_pack_pkg.
module lut_result_pack
  import lut_result_pack_pkg::*;
(
  input  logic                clk,
  input  logic                rst_x,
  input  logic                i_lut_valid,
  input  logic [LANE_W-1:0]   i_lut_result,
  input  logic [NUM_LANE-1:0] i_lut_result_enable,
  input  logic                i_flush,
  output logic                o_in_ready,
  output logic                o_wr_valid,
  input  logic                i_wr_ready,
  output logic [ROW_W-1:0]    o_wr_data,
  output logic [NUM_LANE-1:0] o_wr_mask,
  output logic                o_dup_err,
  output logic [15:0]         o_row_cnt,
  output fill_state_e         o_dbg_state
);

  fill_state_e         r_state;
  fill_state_e         w_state_nxt;
  logic [ROW_W-1:0]    r_fill_data;
  logic [NUM_LANE-1:0] r_fill_mask;
  logic                r_dup_err;
  logic [15:0]         r_row_cnt;

  logic [NUM_LANE-1:0] w_wr_en;
  logic [ROW_W-1:0]    w_post_data;
  logic [NUM_LANE-1:0] w_post_mask;
  logic                w_close;
  logic                w_dup;
  logic                w_slot_free;
  logic                w_load;
  logic [ROW_W-1:0]    w_load_data;
  logic [NUM_LANE-1:0] w_load_mask;
  logic [ROW_W-1:0]    w_fill_data_nxt;
  logic [NUM_LANE-1:0] w_fill_mask_nxt;

  assign o_in_ready  = (r_state == ST_FILL);
  assign o_dup_err   = r_dup_err;
  assign o_row_cnt   = r_row_cnt;
  assign o_dbg_state = r_state;

  // Writes are only taken while filling; in FULL the pending row must not change.
  assign w_wr_en     = (i_lut_valid && o_in_ready) ? i_lut_result_enable : '0;
  assign w_post_mask = r_fill_mask | w_wr_en;
  assign w_dup       = |(r_fill_mask & w_wr_en);
  assign w_close     = o_in_ready && ((&w_post_mask) || (i_flush && (|w_post_mask)));

  always_comb begin
    w_post_data = r_fill_data;
    for (int k = 0; k < NUM_LANE; k++) begin
      if (w_wr_en[k]) begin
        w_post_data[k*LANE_W +: LANE_W] = i_lut_result;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_fill_data_nxt = r_fill_data;
    w_fill_mask_nxt = r_fill_mask;
    w_load          = 1'b0;
    w_load_data     = w_post_data;
    w_load_mask     = w_post_mask;
    case (r_state)
      ST_FILL: begin
        if (w_close && w_slot_free) begin
          // Data is cleared too so unwritten lanes of the next row read as zero.
          w_load          = 1'b1;
          w_fill_data_nxt = '0;
          w_fill_mask_nxt = '0;
        end else begin
          w_fill_data_nxt = w_post_data;
          w_fill_mask_nxt = w_post_mask;
          if (w_close) begin
            w_state_nxt = ST_FULL;
          end
        end
      end
      ST_FULL: begin
        w_load_data = r_fill_data;
        w_load_mask = r_fill_mask;
        if (w_slot_free) begin
          w_load          = 1'b1;
          w_fill_data_nxt = '0;
          w_fill_mask_nxt = '0;
          w_state_nxt     = ST_FILL;
        end
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_x) begin
      r_state     <= ST_FILL;
      r_fill_data <= '0;
      r_fill_mask <= '0;
      r_dup_err   <= 1'b0;
      r_row_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_fill_data <= w_fill_data_nxt;
      r_fill_mask <= w_fill_mask_nxt;
      if (w_dup) begin
        r_dup_err <= 1'b1;
      end
      if (w_load) begin
        r_row_cnt <= r_row_cnt + 16'd1;
      end
    end
  end

  lut_row_slot u_slot (
    .clk     (clk),
    .rst_x   (rst_x),
    .i_load  (w_load),
    .i_data  (w_load_data),
    .i_mask  (w_load_mask),
    .i_ready (i_wr_ready),
    .o_valid (o_wr_valid),
    .o_data  (o_wr_data),
    .o_mask  (o_wr_mask),
    .o_free  (w_slot_free)
  );

endmodule

// File: tb/tb_lut_result_pack.sv
// Directed bench for lut_result_pack: a vector table for single-cycle behaviour and
// hand-written sequences for backpressure, duplicate-lane and mid-row reset cases.
module tb_lut_result_pack;
  import lut_result_pack_pkg::*;

  logic                clk = 1'b0;
  logic                rst_x;
  logic                i_lut_valid;
  logic [LANE_W-1:0]   i_lut_result;
  logic [NUM_LANE-1:0] i_lut_result_enable;
  logic                i_flush;
  logic                o_in_ready;
  logic                o_wr_valid;
  logic                i_wr_ready;
  logic [ROW_W-1:0]    o_wr_data;
  logic [NUM_LANE-1:0] o_wr_mask;
  logic                o_dup_err;
  logic [15:0]         o_row_cnt;
  fill_state_e         o_dbg_state;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lut_result_pack dut (
    .clk                 (clk),
    .rst_x               (rst_x),
    .i_lut_valid         (i_lut_valid),
    .i_lut_result        (i_lut_result),
    .i_lut_result_enable (i_lut_result_enable),
    .i_flush             (i_flush),
    .o_in_ready          (o_in_ready),
    .o_wr_valid          (o_wr_valid),
    .i_wr_ready          (i_wr_ready),
    .o_wr_data           (o_wr_data),
    .o_wr_mask           (o_wr_mask),
    .o_dup_err           (o_dup_err),
    .o_row_cnt           (o_row_cnt),
    .o_dbg_state         (o_dbg_state)
  );

  typedef struct {
    logic                vld;
    logic [NUM_LANE-1:0] en;
    logic [LANE_W-1:0]   dat;
    logic                fl;
    logic                exp_wv;
    logic [NUM_LANE-1:0] exp_mask;
    logic [ROW_W-1:0]    exp_data;
    logic [15:0]         exp_cnt;
  } vec_t;

  localparam int NV = 25;
  vec_t tbl[NV];

  task automatic chk(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [NUM_LANE-1:0] en,
                       input logic [LANE_W-1:0] dat, input logic fl);
    i_lut_valid         = vld;
    i_lut_result_enable = en;
    i_lut_result        = dat;
    i_flush             = fl;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, '0, 1'b0);
    rst_x = 1'b1;
    tick();
    rst_x = 1'b0;
  endtask

  task automatic write_row(input logic [LANE_W-1:0] base, input logic add_idx);
    for (int k = 0; k < NUM_LANE; k++) begin
      drive(1'b1, lane_onehot(k[LANE_IDX_W-1:0]), add_idx ? base + LANE_W'(k) : base, 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    logic [ROW_W-1:0] d;
    rst_x      = 1'b1;
    i_wr_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0);

    for (int i = 0; i < NV; i++) begin
      tbl[i].vld = 1'b0; tbl[i].en = '0; tbl[i].dat = '0; tbl[i].fl = 1'b0;
      tbl[i].exp_wv = 1'b0; tbl[i].exp_mask = '0; tbl[i].exp_data = '0; tbl[i].exp_cnt = '0;
    end
    d = '0;
    for (int k = 0; k < NUM_LANE; k++) begin
      tbl[k].vld     = 1'b1;
      tbl[k].en      = lane_onehot(k[LANE_IDX_W-1:0]);
      tbl[k].dat     = 16'h1000 + 16'(k);
      d[k*16 +: 16]  = 16'h1000 + 16'(k);
    end
    tbl[15].exp_wv = 1'b1; tbl[15].exp_mask = 16'hFFFF; tbl[15].exp_data = d; tbl[15].exp_cnt = 16'd1;
    tbl[16].exp_cnt = 16'd1;
    tbl[17].vld = 1'b1; tbl[17].en = 16'h0008; tbl[17].dat = 16'hABCD; tbl[17].exp_cnt = 16'd1;
    tbl[18].vld = 1'b1; tbl[18].en = 16'h0080; tbl[18].dat = 16'h1234; tbl[18].exp_cnt = 16'd1;
    d = '0; d[3*16 +: 16] = 16'hABCD; d[7*16 +: 16] = 16'h1234;
    tbl[19].fl = 1'b1; tbl[19].exp_wv = 1'b1; tbl[19].exp_mask = 16'h0088; tbl[19].exp_data = d; tbl[19].exp_cnt = 16'd2;
    tbl[20].exp_cnt = 16'd2;
    tbl[21].fl = 1'b1; tbl[21].exp_cnt = 16'd2;
    tbl[22].exp_cnt = 16'd2;
    d = '0; d[0 +: 16] = 16'h5555; d[15*16 +: 16] = 16'h5555;
    tbl[23].vld = 1'b1; tbl[23].en = 16'h8001; tbl[23].dat = 16'h5555; tbl[23].fl = 1'b1;
    tbl[23].exp_wv = 1'b1; tbl[23].exp_mask = 16'h8001; tbl[23].exp_data = d; tbl[23].exp_cnt = 16'd3;
    tbl[24].exp_cnt = 16'd3;

    tick(); tick();
    rst_x = 1'b0;
    chk("rst_wr_valid", o_wr_valid, 0);
    chk("rst_wr_mask", o_wr_mask, 0);
    chk("rst_wr_data", o_wr_data, 0);
    chk("rst_dup_err", o_dup_err, 0);
    chk("rst_row_cnt", o_row_cnt, 0);
    chk("rst_in_ready", o_in_ready, 1);

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].vld, tbl[i].en, tbl[i].dat, tbl[i].fl);
      tick();
      chk($sformatf("v%0d_wr_valid", i), o_wr_valid, tbl[i].exp_wv);
      chk($sformatf("v%0d_row_cnt", i), o_row_cnt, tbl[i].exp_cnt);
      chk($sformatf("v%0d_in_ready", i), o_in_ready, 1);
      chk($sformatf("v%0d_dup_err", i), o_dup_err, 0);
      if (tbl[i].exp_wv) begin
        chk($sformatf("v%0d_wr_mask", i), o_wr_mask, tbl[i].exp_mask);
        chk($sformatf("v%0d_wr_data", i), o_wr_data, tbl[i].exp_data);
      end
    end
    drive(1'b0, '0, '0, 1'b0);

    // Backpressure: two full rows stall, then drain back-to-back.
    do_reset();
    i_wr_ready = 1'b0;
    write_row(16'h0001, 1'b0);
    chk("bp_row1_valid", o_wr_valid, 1);
    chk("bp_row1_cnt", o_row_cnt, 1);
    chk("bp_row1_ready", o_in_ready, 1);
    write_row(16'h0002, 1'b0);
    chk("bp_full_ready", o_in_ready, 0);
    chk("bp_full_cnt", o_row_cnt, 1);
    chk("bp_hold_data", o_wr_data, {16{16'h0001}});
    chk("bp_hold_mask", o_wr_mask, 16'hFFFF);
    drive(1'b1, 16'h0001, 16'hDEAD, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    chk("bp_drop_ready", o_in_ready, 0);
    chk("bp_drop_data", o_wr_data, {16{16'h0001}});
    i_wr_ready = 1'b1;
    tick();
    chk("bp_row2_valid", o_wr_valid, 1);
    chk("bp_row2_data", o_wr_data, {16{16'h0002}});
    chk("bp_row2_cnt", o_row_cnt, 2);
    chk("bp_row2_ready", o_in_ready, 1);
    tick();
    chk("bp_drain_valid", o_wr_valid, 0);
    drive(1'b0, '0, '0, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    tick();
    chk("bp_noflush_valid", o_wr_valid, 0);
    chk("bp_noflush_cnt", o_row_cnt, 2);

    // Duplicate lane write sets a sticky error.
    do_reset();
    drive(1'b1, 16'h0020, 16'h0001, 1'b0);
    tick();
    chk("dup_first", o_dup_err, 0);
    drive(1'b1, 16'h0020, 16'h0002, 1'b0);
    tick();
    chk("dup_second", o_dup_err, 1);
    drive(1'b0, '0, '0, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    chk("dup_valid", o_wr_valid, 1);
    chk("dup_mask", o_wr_mask, 16'h0020);
    d = '0; d[5*16 +: 16] = 16'h0002;
    chk("dup_data", o_wr_data, d);
    write_row(16'h0100, 1'b1);
    chk("dup_sticky", o_dup_err, 1);
    chk("dup_sticky_cnt", o_row_cnt, 2);
    do_reset();
    chk("dup_cleared", o_dup_err, 0);

    // Reset while a row is held in the slot and a partial row is buffered.
    i_wr_ready = 1'b0;
    write_row(16'h0200, 1'b1);
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, lane_onehot(k[LANE_IDX_W-1:0]), 16'h0300, 1'b0);
      tick();
    end
    chk("mr_pre_valid", o_wr_valid, 1);
    do_reset();
    chk("mr_valid", o_wr_valid, 0);
    chk("mr_data", o_wr_data, 0);
    chk("mr_mask", o_wr_mask, 0);
    chk("mr_cnt", o_row_cnt, 0);
    chk("mr_ready", o_in_ready, 1);
    i_wr_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    tick();
    chk("mr_flush_valid", o_wr_valid, 0);
    chk("mr_flush_cnt", o_row_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lut_result_pack.md
Name: lut_result_pack

Overview:
- Write-side counterpart of the PIM LUT lookup path.
- The lookup side selects one 16-bit entry from a 256-bit memory row for a one-hot accumulator lane. This block does the reverse: it gathers per-lane 16-bit results, each tagged with a one-hot lane enable, into a 256-bit row plus a lane mask.
- It hands completed or flushed rows to the memory write port over a valid/ready handshake.
- Sits between the accumulator/LUT result stage and the bank write-data path.

Parameters:
- NUM_LANE, 16, number of accumulator lanes per row.
- LANE_W, 16, bits per lane entry.
- ROW_W, NUM_LANE*LANE_W (256), width of the packed row; derived, not overridable.

Ports:
- clk  in  1  clock.
- rst_x  in  1  reset, synchronous, active-high (asserted = 1 resets on the next clk edge).
- i_lut_valid  in  1  lane write strobe.
- i_lut_result  in  LANE_W  lane data.
- i_lut_result_enable  in  NUM_LANE  lane select; normally one-hot.
- i_flush  in  1  emit the current partial row.
- o_in_ready  out  1  block can accept i_lut_valid / i_flush this cycle.
- o_wr_valid  out  1  output row valid.
- i_wr_ready  in  1  write port accepts the row.
- o_wr_data  out  ROW_W  packed row; lane k occupies bits [16k+15:16k].
- o_wr_mask  out  NUM_LANE  lanes written in this row.
- o_dup_err  out  1  sticky: a lane was written twice within one row.
- o_row_cnt  out  16  rows handed off; wraps at 2^16.

Behaviour:
Storage
- Fill buffer: fill_data, fill_mask.
- Output slot: o_wr_data, o_wr_mask, o_wr_valid.

Reset (rst_x=1 at a clk edge)
- All of the following clear to 0: fill_data, fill_mask, o_wr_data, o_wr_mask, o_wr_valid, o_dup_err, o_row_cnt.
- o_in_ready = 1 after reset.
- Reset mid-row or mid-handshake discards all held data. No write is issued.

Lane write (i_lut_valid & o_in_ready)
- For every bit k set in i_lut_result_enable: fill_data lane k <= i_lut_result, and fill_mask[k] <= 1.
- Enable = 0 is a no-op.
- More than one bit set: all selected lanes are written (broadcast). This is legal.
- If any selected lane already has fill_mask[k]=1: data is overwritten and o_dup_err is set. o_dup_err stays 1 until reset.

Row close
- A row closes when the mask after this cycle's write is all-ones, OR when i_flush & o_in_ready with the post-write mask non-zero.
- Flush with an empty mask (and no same-cycle write) is a no-op. o_row_cnt is unchanged.
- A write and a flush in the same cycle: the write is included, then the row closes.

Handoff on close
- If the output slot is free (o_wr_valid=0, or o_wr_valid & i_wr_ready this cycle):
  - The row moves to the output slot at the same edge, so o_wr_valid=1 in the next cycle.
  - fill_mask clears to 0 and o_row_cnt increments.
  - Latency: last lane write in cycle N gives o_wr_valid in cycle N+1.
- Otherwise the row stays pending in the fill buffer (state FULL) and o_in_ready=0.

Fill FSM
- FILL -> FULL: on row close while the slot is busy.
- FULL -> FILL: on the cycle the slot frees (i_wr_ready with o_wr_valid). The pending row moves in and o_row_cnt increments.
- o_in_ready = (state == FILL).

Output handshake
- o_wr_valid holds until i_wr_ready.
- o_wr_data and o_wr_mask are stable while o_wr_valid & !i_wr_ready.
- i_wr_ready while o_wr_valid=0 is ignored.

Inputs while not ready
- i_lut_valid or i_flush with o_in_ready=0 are ignored (dropped). Upstream must hold them.

Throughput
- With i_wr_ready tied to 1: one row per 16 accepted single-lane writes, with no bubble between rows.

Decomposition:
- Shared package: NUM_LANE, LANE_W, ROW_W constants; a lane-index-to-one-hot decode function; the fill FSM state enum {FILL, FULL}. The lookup block also uses the lane constants and decode from this package.
- One natural sub-module: lut_row_slot, the single-entry valid/ready output register holding data and mask.

Test Plan:
- Reset, then write lanes 0..15 in order with values 16'h1000+k, wr_ready=1 -> o_wr_valid in the cycle after the 16th write; o_wr_data lane k = 16'h1000+k; o_wr_mask = 16'hFFFF; o_row_cnt = 1; o_dup_err = 0.
- Write lanes 3 (16'hABCD) and 7 (16'h1234), then flush -> o_wr_mask = 16'h0088; lane 3 = 16'hABCD; lane 7 = 16'h1234; all other lanes 0. Flush on an empty buffer -> no o_wr_valid and o_row_cnt unchanged.
- wr_ready=0; fill two full rows (values 1 then 2) -> after the second row closes, o_in_ready=0 and further writes are dropped. Raise wr_ready -> row 1 then row 2 are issued back-to-back; o_row_cnt = 2; o_in_ready returns to 1.
- Write lane 5 twice with 16'h0001 then 16'h0002, then flush -> lane 5 = 16'h0002; o_dup_err = 1, and it stays 1 across later rows until reset.
- Enable = 16'h8001 with data 16'h5555 in one cycle -> lanes 0 and 15 both = 16'h5555; mask bits 0 and 15 set.
- Assert rst_x while a 10-lane partial row is buffered and o_wr_valid=1 -> next cycle all outputs are 0 and o_in_ready=1. A subsequent flush produces nothing.
